// File: rtl/custom_apb_key_pkg.sv
// Shared constants for the key input peripheral and its APB register wrapper.
package custom_apb_key_pkg;

    // Status words presented to the register wrapper are always this wide.
    localparam int MAX_KEYS      = 32;

    // 10 ms of stable level at 50 MHz before a new key level is accepted.
    localparam int DEF_DB_CYCLES = 500000;

    // Counter width that can hold DEF_DB_CYCLES-1.
    localparam int DEF_CNT_W     = 20;

endpackage

// File: rtl/custom_apb_key_if.sv
// Signal bundle between the key peripheral and its register wrapper / pads.
// keyIn and keyClr are sampled on every clk edge: keyClr is a one-cycle
// write-1-to-clear strobe with no valid/ready pairing. keyState, keyEvent and
// keyIrq are registered levels that are valid on every cycle.
interface custom_apb_key_if #(
    parameter int KEY_NUM = 4
);
    logic [KEY_NUM-1:0]                       keyIn;
    logic [KEY_NUM-1:0]                       keyClr;
    logic [custom_apb_key_pkg::MAX_KEYS-1:0]  keyState;
    logic [custom_apb_key_pkg::MAX_KEYS-1:0]  keyEvent;
    logic                                     keyIrq;

    modport master (
        output keyIn,
        output keyClr,
        input  keyState,
        input  keyEvent,
        input  keyIrq
    );

    modport slave (
        input  keyIn,
        input  keyClr,
        output keyState,
        output keyEvent,
        output keyIrq
    );
endinterface

// File: rtl/custom_apb_key_debounce.sv
// One key: two-flop synchroniser, debounce counter and accepted (stable) level.
// Levels are active-low at the pad: stable = 1 means released.
module custom_apb_key_debounce #(
    parameter int CNT_W     = 20,
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic stable_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronised level disagrees with the
    // accepted level; any agreement restarts the count, so it never wraps.
    always_comb begin
        s1_d     = key_in;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // Press = accepted level falls from released to pressed.
        press_d = stable_q & ~stable_d;
    end

    // State registers; reset puts the key in the released state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;

endmodule

// File: rtl/custom_apb_key.sv
// Debounced push-button peripheral: live pressed levels, sticky press flags
// (write-1-to-clear) and a level interrupt while any flag is set.
module custom_apb_key
    import custom_apb_key_pkg::*;
#(
    parameter int KEY_NUM   = 4,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    custom_apb_key_if.slave    bus
);

    logic [KEY_NUM-1:0] stable;
    logic [KEY_NUM-1:0] press;

    logic [KEY_NUM-1:0] key_state_q, key_state_d;
    logic [KEY_NUM-1:0] key_event_q, key_event_d;
    logic               key_irq_q, key_irq_d;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
        custom_apb_key_debounce #(
            .CNT_W     (CNT_W),
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .key_in   (bus.keyIn[i]),
            .stable_o (stable[i]),
            .press_o  (press[i])
        );
    end

    // Press pulse lands on the same edge the pressed level rises; a press
    // arriving together with a clear strobe keeps the flag set.
    always_comb begin
        key_state_d = ~stable;
        key_event_d = (key_event_q & ~bus.keyClr) | press;
        key_irq_d   = |key_event_d;
    end

    // Status registers; interrupt tracks next-state flags so it moves with them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_state_q <= '0;
            key_event_q <= '0;
            key_irq_q   <= 1'b0;
        end else begin
            key_state_q <= key_state_d;
            key_event_q <= key_event_d;
            key_irq_q   <= key_irq_d;
        end
    end

    assign bus.keyState = MAX_KEYS'(key_state_q);
    assign bus.keyEvent = MAX_KEYS'(key_event_q);
    assign bus.keyIrq   = key_irq_q;

endmodule

// File: tb/tb_custom_apb_key.sv
// Bench for custom_apb_key with DB_CYCLES=4, KEY_NUM=4: directed scenarios
// plus randomized key activity, all checked by a cycle scoreboard against a
// sample-window reference model.
module tb_custom_apb_key;

    localparam int KN = 4;
    localparam int DB = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    custom_apb_key_if #(.KEY_NUM(KN)) bus ();

    custom_apb_key #(
        .KEY_NUM   (KN),
        .CNT_W     (CW),
        .DB_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // {keyState[31:0], keyEvent[31:0], keyIrq}
    logic [64:0] exp_q[$];

    // Reference model: accepted level flips once the last DB synchronised
    // samples all disagree with it; outputs lag the accepted level by a cycle.
    logic [KN-1:0] m_stable;
    logic [KN-1:0] m_state;
    logic [KN-1:0] m_event;
    logic [KN-1:0] m_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_stable = '1;
        m_state  = '0;
        m_event  = '0;
        m_hist   = {};
        for (int j = 0; j <= DB; j++) m_hist.push_back('1);
    endtask

    // Advance the model by one clock edge that samples keyIn=k, keyClr=c.
    task automatic model_step(input logic [KN-1:0] k, input logic [KN-1:0] c);
        logic [KN-1:0] ns_state;
        logic [KN-1:0] ns_event;
        logic          all_diff;
        ns_state = ~m_stable;
        ns_event = (m_event & ~c) | (ns_state & ~m_state);
        for (int i = 0; i < KN; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++)
                if (m_hist[j][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) m_stable[i] = ~m_stable[i];
        end
        m_state = ns_state;
        m_event = ns_event;
        m_hist.push_back(k);
        void'(m_hist.pop_front());
        exp_q.push_back({32'(m_state), 32'(m_event), |m_event});
    endtask

    task automatic apply(input logic [KN-1:0] k, input logic [KN-1:0] c);
        bus.keyIn  = k;
        bus.keyClr = c;
        model_step(k, c);
    endtask

    task automatic drive(input logic [KN-1:0] k, input logic [KN-1:0] c);
        @(negedge clk);
        apply(k, c);
    endtask

    task automatic release_reset(input logic [KN-1:0] k);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        apply(k, 0);
    endtask

    task automatic enter_reset(input logic [KN-1:0] k);
        @(negedge clk);
        rst        = 1'b0;
        bus.keyIn  = k;
        bus.keyClr = '0;
        #1;
        check("rst_state", bus.keyState, 32'h0);
        check("rst_event", bus.keyEvent, 32'h0);
        check("rst_irq",   32'(bus.keyIrq), 32'h0);
        repeat (3) @(negedge clk);
        check("rst_hold_state", bus.keyState, 32'h0);
        check("rst_hold_event", bus.keyEvent, 32'h0);
        check("rst_hold_irq",   32'(bus.keyIrq), 32'h0);
    endtask

    // The first sampling edge has already been driven by the caller; returns
    // how many edges after it keyState[b] first reads 1 (-1 on timeout).
    task automatic wait_key(input logic [KN-1:0] k, input logic [KN-1:0] c,
                            input int b, output int lat);
        lat = -1;
        for (int n = 0; n <= 20; n++) begin
            @(posedge clk);
            #2;
            if (bus.keyState[b]) begin
                lat = n;
                break;
            end
            drive(k, c);
        end
    endtask

    // Scoreboard monitor: one expected entry per clock edge while out of reset.
    initial begin
        logic [64:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_state", bus.keyState, e[64:33]);
                check("sb_event", bus.keyEvent, e[32:1]);
                check("sb_irq",   32'(bus.keyIrq), 32'(e[0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic [KN-1:0] rk;
        logic [KN-1:0] rc;

        // 1: reset with every key pressed at the pads
        rst        = 1'b0;
        bus.keyIn  = '0;
        bus.keyClr = '0;
        model_reset();
        enter_reset(4'b0000);

        // 2: clean press of key0
        release_reset(4'b1111);
        repeat (3) drive(4'b1111, 4'b0000);
        drive(4'b1110, 4'b0000);
        wait_key(4'b1110, 4'b0000, 0, lat);
        check("press_latency", 32'(lat), 32'd6);
        check("press_state", bus.keyState, 32'h1);
        check("press_event", bus.keyEvent, 32'h1);
        check("press_irq",   32'(bus.keyIrq), 32'h1);

        // 3: glitch on key1 shorter than the debounce window
        repeat (3) drive(4'b1100, 4'b0000);
        repeat (8) drive(4'b1110, 4'b0000);
        @(posedge clk);
        #2;
        check("glitch_state", bus.keyState, 32'h1);
        check("glitch_event", bus.keyEvent, 32'h1);

        // 4: release key0, flag persists until cleared
        repeat (8) drive(4'b1111, 4'b0000);
        @(posedge clk);
        #2;
        check("release_state", bus.keyState, 32'h0);
        check("release_event", bus.keyEvent, 32'h1);
        drive(4'b1111, 4'b0001);
        @(posedge clk);
        #2;
        check("clear_event", bus.keyEvent, 32'h0);
        check("clear_irq",   32'(bus.keyIrq), 32'h0);
        drive(4'b1111, 4'b0001);
        @(posedge clk);
        #2;
        check("clear_zero_event", bus.keyEvent, 32'h0);

        // 5: clear held on key2 across its press edge
        drive(4'b1011, 4'b0100);
        wait_key(4'b1011, 4'b0100, 2, lat);
        check("collide_latency", 32'(lat), 32'd6);
        check("collide_event",   bus.keyEvent, 32'h4);
        check("collide_irq",     32'(bus.keyIrq), 32'h1);
        drive(4'b1011, 4'b0000);
        @(posedge clk);
        #2;
        check("collide_hold_event", bus.keyEvent, 32'h4);
        repeat (8) drive(4'b1111, 4'b0000);
        drive(4'b1111, 4'b0100);
        drive(4'b1111, 4'b0000);

        // 6: reset while key3 is part way through debouncing
        repeat (4) drive(4'b0111, 4'b0000);
        @(posedge clk);
        #2;
        check("middb_state", bus.keyState, 32'h0);
        enter_reset(4'b0111);
        release_reset(4'b0111);
        wait_key(4'b0111, 4'b0000, 3, lat);
        check("rst_redb_latency", 32'(lat), 32'd6);
        check("rst_redb_event",   bus.keyEvent, 32'h8);
        check("rst_redb_irq",     32'(bus.keyIrq), 32'h1);
        repeat (8) drive(4'b1111, 4'b0000);
        drive(4'b1111, 4'b1000);

        // 7: randomized key activity with occasional clears
        rk = '1;
        for (int t = 0; t < 2000; t++) begin
            for (int i = 0; i < KN; i++) begin
                if ($urandom_range(0, 9) == 0) rk[i] = ~rk[i];
                rc[i] = ($urandom_range(0, 7) == 0);
            end
            drive(rk, rc);
        end

        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
